mul_ctrl: RTL
=============

Name: mul_ctrl

Overview:
- EX-stage sequencer for the multi-cycle multiplier unit (start/annul/ready handshake).
- Decodes the multiply op class and latches operands for the whole operation.
- Holds the pipeline via stall_o; performs the HI/LO accumulate step for MADD/MSUB.
- Delivers a one-cycle write strobe to HI/LO or the GPR file; aborts cleanly on pipeline flush.

Parameters:
WATCHDOG, 32, max cycles in BUSY waiting for mul_ready_i; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op_i  in  3  000 none, 001 MULT, 010 MULTU, 011 MADD, 100 MADDU, 101 MSUB, 110 MSUBU, 111 MUL (GPR)
rs_i  in  32  operand A
rt_i  in  32  operand B
hilo_i  in  64  current {HI,LO}, already forwarded
flush_i  in  1  pipeline flush, kills the in-flight op
stall_o  out  1  hold the EX stage
mul_signed_o  out  1  to multiplier
mul_op1_o  out  32  to multiplier
mul_op2_o  out  32  to multiplier
mul_start_o  out  1  to multiplier
mul_annul_o  out  1  to multiplier
mul_result_i  in  64  from multiplier
mul_ready_i  in  1  from multiplier
result_o  out  64  final value, {HI,LO} or product
hilo_we_o  out  1  write result_o to HI/LO, 1-cycle pulse
gpr_we_o  out  1  write result_o[31:0] to rd, 1-cycle pulse (MUL)
err_o  out  1  watchdog expiry pulse

Behaviour:
- Reset: FSM to IDLE; all registered outputs and latches cleared; result_o=0; strobes 0.
- States: IDLE, BUSY, ACC, DONE.
- Signed ops: MULT, MADD, MSUB, MUL. Unsigned ops: MULTU, MADDU, MSUBU.
- IDLE, op_i!=0 and !flush_i:
  - latch rs_i, rt_i, signedness, op and hilo_i.
  - mul_op1_o/mul_op2_o/mul_signed_o bypass the inputs this cycle; afterwards they come from the latches.
  - mul_start_o=1, stall_o=1; next state BUSY.
- IDLE, op_i==0 or flush_i: all strobes 0, stall_o=0.
- BUSY:
  - mul_start_o=1, stall_o=1, operands stable.
  - On mul_ready_i=1: capture mul_result_i into the product register. Next state ACC for MADD/MADDU/MSUB/MSUBU, else DONE.
- ACC (exactly one cycle), stall_o=1, mul_start_o=0:
  - result = hilo_latched + product (MADD*) or hilo_latched - product (MSUB*).
  - 64-bit modulo 2^64 arithmetic, same for signed and unsigned.
  - Next state DONE.
- DONE (exactly one cycle), stall_o=0, mul_start_o=0:
  - result_o holds the final value.
  - hilo_we_o=1 for ops 001..110; gpr_we_o=1 for 111.
  - op_i is ignored this cycle, so the same instruction never restarts. Next state IDLE.
- Dropping mul_start_o in ACC/DONE returns the multiplier to its idle state. A new op may therefore start in the cycle after DONE.
- Latency: stall cycles = multiplier latency + 1 for plain ops, +2 for accumulate ops. result_o is valid in the DONE cycle.
- flush_i (combinational into outputs):
  - mul_annul_o = flush_i && state in {BUSY, ACC}; mul_start_o forced 0 while flush_i.
  - BUSY/ACC + flush_i: next state IDLE, no strobes, stall_o=0.
  - DONE + flush_i: strobes suppressed; next state IDLE.
- Watchdog (WATCHDOG>0):
  - counter cleared on entry to BUSY, increments each BUSY cycle.
  - Reaching WATCHDOG: mul_annul_o=1 and err_o=1 for one cycle, no write strobes, next state IDLE.
- mul_ready_i outside BUSY: ignored.
- rst mid-operation: FSM to IDLE next edge; mul_start_o=0 after reset; no strobe is produced for the aborted op.

Optional Feature:
- Macro MUL_CTRL_ACC_EN.
- Defined: MADD/MADDU/MSUB/MSUBU behave as above, including the ACC state.
- Undefined: ACC state and the hilo latch are not built; op_i 011..110 are treated as 000 (no start, no stall, no strobes).

Test Plan:
1. MULT, rs=0xFFFFFFFE (-2), rt=3 -> stall until ready, DONE: result_o=0xFFFFFFFF_FFFFFFFA, hilo_we_o=1 for one cycle.
2. MULTU, rs=0xFFFFFFFF, rt=0xFFFFFFFF -> result_o=0xFFFFFFFE_00000001; mul_signed_o=0 throughout BUSY.
3. MADD, hilo=0x00000000_00000010, rs=4, rt=5 -> result_o=0x24, one extra ACC stall cycle. MSUBU, hilo=0, rs=1, rt=1 -> result_o=0xFFFFFFFF_FFFFFFFF.
4. MUL, rs=7, rt=6 -> gpr_we_o=1, result_o[31:0]=42, hilo_we_o=0. A second MUL presented the cycle after DONE starts immediately and completes correctly.
5. flush_i asserted 3 cycles into BUSY -> mul_annul_o=1 that cycle, stall_o=0, no strobes. A following MULT 2×2 yields 4.
6. WATCHDOG=4 with mul_ready_i tied 0 -> err_o pulses on the 4th BUSY cycle, mul_annul_o=1, state returns to IDLE. rst asserted during BUSY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mul_ctrl.sv
// EX-stage sequencer for the multi-cycle multiplier: launch, wait, optional HI/LO accumulate, write strobe.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MUL_CTRL_ACC_EN is defined.
module mul_ctrl #(
    parameter int WATCHDOG = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [63:0] hilo_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        mul_signed_o,
    output logic [31:0] mul_op1_o,
    output logic [31:0] mul_op2_o,
    output logic        mul_start_o,
    output logic        mul_annul_o,
    input  logic [63:0] mul_result_i,
    input  logic        mul_ready_i,
    output logic [63:0] result_o,
    output logic        hilo_we_o,
    output logic        gpr_we_o,
    output logic        err_o
);

    // state  | meaning
    // IDLE   | waiting for a multiply op; launches in the same cycle it is seen
    // BUSY   | multiplier running, operands held stable from the latches
    // ACC    | one cycle: {HI,LO} +/- product
    // DONE   | one cycle: result_o valid, write strobe, op_i ignored
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int WD_W = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (WATCHDOG > 0) ? WD_W'(WATCHDOG - 1) : '0;

    state_t            r_state;
    logic [31:0]       r_op1;
    logic [31:0]       r_op2;
    logic              r_signed;
    logic              r_gpr;
    logic [63:0]       r_result;
    logic [WD_W-1:0]   r_wdog;
`ifdef MUL_CTRL_ACC_EN
    logic              r_acc;
    logic              r_sub;
    logic [63:0]       r_hilo;
    logic [63:0]       r_prod;
    logic              w_acc;
    logic              w_sub;
`else
    logic              w_unused_hilo;
`endif

    logic w_op_valid;
    logic w_signed;
    logic w_gpr;
    logic w_launch;
    logic w_wd_hit;

    always_comb begin
        w_op_valid = 1'b0;
        w_signed   = 1'b0;
        w_gpr      = 1'b0;
`ifdef MUL_CTRL_ACC_EN
        w_acc      = 1'b0;
        w_sub      = 1'b0;
`endif
        case (op_i)
            3'b001: begin w_op_valid = 1'b1; w_signed = 1'b1; end
            3'b010: begin w_op_valid = 1'b1; end
`ifdef MUL_CTRL_ACC_EN
            3'b011: begin w_op_valid = 1'b1; w_signed = 1'b1; w_acc = 1'b1; end
            3'b100: begin w_op_valid = 1'b1; w_acc = 1'b1; end
            3'b101: begin w_op_valid = 1'b1; w_signed = 1'b1; w_acc = 1'b1; w_sub = 1'b1; end
            3'b110: begin w_op_valid = 1'b1; w_acc = 1'b1; w_sub = 1'b1; end
`endif
            3'b111: begin w_op_valid = 1'b1; w_signed = 1'b1; w_gpr = 1'b1; end
            default: ;
        endcase
    end

`ifndef MUL_CTRL_ACC_EN
    assign w_unused_hilo = ^hilo_i;
`endif

    assign w_launch = (r_state == S_IDLE) && w_op_valid && !flush_i;

    // A ready in the expiry cycle still wins; flush beats both.
    assign w_wd_hit = (WATCHDOG > 0) && (r_state == S_BUSY) && !flush_i
                      && !mul_ready_i && (r_wdog == WD_LAST);

    assign mul_op1_o    = w_launch ? rs_i : r_op1;
    assign mul_op2_o    = w_launch ? rt_i : r_op2;
    assign mul_signed_o = w_launch ? w_signed : r_signed;

    assign mul_start_o = !flush_i && (w_launch || ((r_state == S_BUSY) && !w_wd_hit));
    assign mul_annul_o = (flush_i && ((r_state == S_BUSY) || (r_state == S_ACC))) || w_wd_hit;
    assign stall_o     = w_launch
                         || ((r_state == S_BUSY) && !flush_i && !w_wd_hit)
                         || ((r_state == S_ACC) && !flush_i);

    assign hilo_we_o = (r_state == S_DONE) && !flush_i && !r_gpr;
    assign gpr_we_o  = (r_state == S_DONE) && !flush_i && r_gpr;
    assign err_o     = w_wd_hit;
    assign result_o  = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op1    <= '0;
            r_op2    <= '0;
            r_signed <= 1'b0;
            r_gpr    <= 1'b0;
            r_result <= '0;
            r_wdog   <= '0;
`ifdef MUL_CTRL_ACC_EN
            r_acc    <= 1'b0;
            r_sub    <= 1'b0;
            r_hilo   <= '0;
            r_prod   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_op1    <= rs_i;
                        r_op2    <= rt_i;
                        r_signed <= w_signed;
                        r_gpr    <= w_gpr;
                        r_wdog   <= '0;
`ifdef MUL_CTRL_ACC_EN
                        r_acc    <= w_acc;
                        r_sub    <= w_sub;
                        r_hilo   <= hilo_i;
`endif
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else if (mul_ready_i) begin
`ifdef MUL_CTRL_ACC_EN
                        r_prod <= mul_result_i;
                        if (r_acc) begin
                            r_state <= S_ACC;
                        end else begin
                            r_result <= mul_result_i;
                            r_state  <= S_DONE;
                        end
`else
                        r_result <= mul_result_i;
                        r_state  <= S_DONE;
`endif
                    end else if (w_wd_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
`ifdef MUL_CTRL_ACC_EN
                S_ACC: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= r_sub ? (r_hilo - r_prod) : (r_hilo + r_prod);
                        r_state  <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
